// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CHECK,
        ST_DONE
    } ccff_ld_state_t;

    // Width able to hold the value n itself (the remaining-bit counter starts at CHAIN_LEN).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word parallel-to-serial register, MSB first, with a per-word bit counter.
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_in_load,
    input  logic              i_in_shift,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_msb,
    output logic              o_last_bit
);

    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] r_sreg;
    logic [BC_W-1:0]   r_bit_cnt;
    logic              w_load;
    logic              w_shift;

    assign w_load  = i_in_load & i_valid;
    assign w_shift = i_in_shift;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sreg    <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_sreg    <= i_data;
            r_bit_cnt <= '0;
        end else if (w_shift) begin
            r_sreg    <= r_sreg << 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign o_msb      = r_sreg[WORD_W-1];
    // High during the shift cycle that emits the word's last bit.
    assign o_last_bit = (r_bit_cnt == BC_W'(WORD_W - 1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words onto a configuration chain and checks the tail after the last shift.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output ccff_ld_state_t    dbg_state
);

    // Handshake: a word transfers in a cycle where cfg_ready and cfg_valid are both 1
    // at the rising edge of prog_clk; cfg_ready never depends on cfg_valid.

    ccff_ld_state_t   r_state;
    logic [CNT_W-1:0] r_remaining;
    logic             r_first_bit;
    logic             r_first_seen;
    logic             r_error;

    logic w_in_load;
    logic w_in_shift;
    logic w_msb;
    logic w_last_bit;

    assign w_in_load  = (r_state == ST_LOAD);
    assign w_in_shift = (r_state == ST_SHIFT);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .i_clk      (prog_clk),
        .i_reset    (prog_reset),
        .i_in_load  (w_in_load),
        .i_in_shift (w_in_shift),
        .i_valid    (cfg_valid),
        .i_data     (cfg_data),
        .o_msb      (w_msb),
        .o_last_bit (w_last_bit)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_first_bit  <= 1'b0;
            r_first_seen <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_LOAD;
                        r_remaining  <= CNT_W'(CHAIN_LEN);
                        r_error      <= 1'b0;
                        r_first_seen <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (cfg_valid) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_remaining <= r_remaining - 1'b1;
                    if (!r_first_seen) begin
                        r_first_bit  <= w_msb;
                        r_first_seen <= 1'b1;
                    end
                    // Chain full wins over end-of-word: leftover LSBs are dropped.
                    if (r_remaining == CNT_W'(1)) begin
                        r_state <= ST_CHECK;
                    end else if (w_last_bit) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_CHECK: begin
                    // The first bit shifted must have travelled exactly to the tail.
                    r_error <= (ccff_tail != r_first_bit);
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready     = w_in_load;
    assign ccff_shift_en = w_in_shift;
    assign ccff_head     = w_in_shift & w_msb;
    assign busy          = w_in_load | w_in_shift | (r_state == ST_CHECK);
    assign done          = (r_state == ST_DONE);
    assign error         = r_error;
    assign dbg_state     = r_state;

endmodule
